// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART TX drain path.
//   - uart_state_t : serializer bit-timing states
//   - memory-map offsets of the TX ring buffer, tail and head registers
//   - ring size in bytes
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam logic [31:0] UART_TX_BUFFER_OFFSET     = 32'hff000000;
    localparam logic [31:0] UART_TX_QUEUE_TAIL_OFFSET = 32'hff000100;
    localparam logic [31:0] UART_TX_QUEUE_HEAD_OFFSET = 32'hff000104;

    localparam int unsigned UART_TX_QUEUE_BYTES = 256;

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 serializer with registered line output.
// Ports:
//   clk, rst_n   : system clock, synchronous active-low reset
//   tx_byte      : byte to send, captured when valid is seen in IDLE
//   valid        : a byte is available
//   ready        : serializer is in IDLE and can take a byte
//   done         : one-cycle pulse on the last STOP cycle (STOP->IDLE edge)
//   tx           : serial line, idle high
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_byte,
    input  logic       valid,
    output logic       ready,
    output logic       done,
    output logic       tx
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t   state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = (clk_cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + CW'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (valid) begin
                    shift_d = tx_byte;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    done      = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level is derived from the next state so the registered
        // output changes on the same edge as the state it belongs to.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign ready = (state_q == IDLE);
    assign tx    = tx_q;

endmodule

// File: rtl/uart_tx_drainer.sv
// uart_tx_drainer: drains the memory-mapped UART TX ring buffer onto a
// serial line, one 8N1 frame per byte, advancing the queue head after
// each completed frame.
// Ports:
//   clk, rst_n          : system clock, synchronous active-low reset
//   uart_tx_buffer      : 64 x 32-bit ring words; byte i = word i[7:2], lane i[1:0]
//   uart_tx_queue_tail  : producer index, bits [7:0] used
//   uart_tx_queue_head  : consumer index, zero-extended 8-bit head
//   uart_tx             : serial line, idle high
//   busy                : a frame is in progress
module uart_tx_drainer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 27000000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] uart_tx_buffer [64],
    input  logic [31:0] uart_tx_queue_tail,
    output logic [31:0] uart_tx_queue_head,
    output logic        uart_tx,
    output logic        busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_drainer: CLK_FREQ/BAUD_RATE must be at least 2");
    end

    logic [7:0]  head_q;
    logic [31:0] cur_word;
    logic [7:0]  cur_byte;
    logic        ser_ready;
    logic        ser_done;
    logic        tx_valid;
    logic        unused_tail_hi;

    // Only the low byte of the tail is an index; the rest is ignored.
    assign unused_tail_hi = ^uart_tx_queue_tail[31:8];

    assign cur_word = uart_tx_buffer[head_q[7:2]];
    assign cur_byte = cur_word[{head_q[1:0], 3'b000} +: 8];
    assign tx_valid = ser_ready && (head_q != uart_tx_queue_tail[7:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
        end else if (ser_done) begin
            head_q <= head_q + 8'd1;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serializer (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_byte (cur_byte),
        .valid   (tx_valid),
        .ready   (ser_ready),
        .done    (ser_done),
        .tx      (uart_tx)
    );

    assign uart_tx_queue_head = {24'd0, head_q};
    assign busy               = ~ser_ready;

endmodule

// File: tb/tb_uart_tx_drainer.sv
// tb_uart_tx_drainer: directed, table-driven bench for uart_tx_drainer
// at CLK_FREQ=8, BAUD_RATE=2 (4 clocks per bit). Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_uart_tx_drainer;

    localparam int unsigned CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tx_buf [64];
    logic [31:0] tail;
    logic [31:0] head_out;
    logic        uart_tx;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  exp_head;

    typedef struct {
        logic        rst_first;
        logic [31:0] tail;
        int unsigned nbytes;
        logic [31:0] bytes;   // byte k in bits [8k+7:8k]
    } vec_t;

    vec_t vecs [3];

    uart_tx_drainer #(
        .CLK_FREQ  (8),
        .BAUD_RATE (2)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .uart_tx_buffer     (tx_buf),
        .uart_tx_queue_tail (tail),
        .uart_tx_queue_head (head_out),
        .uart_tx            (uart_tx),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic idle_hold(input int unsigned cycles, input logic [7:0] hd);
        for (int unsigned c = 0; c < cycles; c++) begin
            chk("idle_tx", {31'd0, uart_tx}, 32'd1);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_head", head_out, {24'd0, hd});
            tick();
        end
    endtask

    // Called on the falling edge of the first START cycle; returns on the
    // falling edge one cycle after the IDLE cycle that follows the frame.
    task automatic frame(input logic [7:0] b, input logic [7:0] hd_after);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int unsigned p = 0; p < 10; p++) begin
            for (int unsigned k = 0; k < CPB; k++) begin
                chk("frame_tx", {31'd0, uart_tx}, {31'd0, bits[p]});
                if (k == 0) chk("frame_busy", {31'd0, busy}, 32'd1);
                tick();
            end
        end
        chk("gap_tx", {31'd0, uart_tx}, 32'd1);
        chk("gap_busy", {31'd0, busy}, 32'd0);
        chk("head_after_frame", head_out, {24'd0, hd_after});
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tail  = 32'd0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_tx", {31'd0, uart_tx}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_head", head_out, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tx_buf[i] = 32'd0;
        rst_n = 1'b0;
        tail  = 32'd0;
        tick();

        // Reset state held for 100 cycles with an empty queue.
        do_reset();
        idle_hold(100, 8'd0);

        tx_buf[0] = 32'h44434241;

        vecs[0] = '{rst_first: 1'b0, tail: 32'd1,         nbytes: 1, bytes: 32'h00000041};
        vecs[1] = '{rst_first: 1'b1, tail: 32'd4,         nbytes: 4, bytes: 32'h44434241};
        vecs[2] = '{rst_first: 1'b1, tail: 32'h00000100,  nbytes: 0, bytes: 32'h00000000};

        exp_head = 8'd0;
        for (int v = 0; v < 3; v++) begin
            if (vecs[v].rst_first) begin
                do_reset();
                exp_head = 8'd0;
            end
            tail = vecs[v].tail;
            tick();
            if (vecs[v].nbytes == 0) begin
                idle_hold(50, exp_head);
            end else begin
                for (int unsigned i = 0; i < vecs[v].nbytes; i++) begin
                    exp_head = exp_head + 8'd1;
                    frame(vecs[v].bytes[8*i +: 8], exp_head);
                end
                idle_hold(20, exp_head);
            end
        end

        // Head wrap 255 -> 0 -> 1.
        do_reset();
        tx_buf[63] = 32'hA5000000;
        tx_buf[0]  = 32'h4443425A;
        tail = 32'd255;
        begin
            int unsigned cyc;
            cyc = 0;
            while (head_out != 32'd255 && cyc < 12000) begin
                tick();
                cyc++;
            end
            chk("drain_to_255", head_out, 32'd255);
        end
        tail = 32'd1;
        tick();
        frame(8'hA5, 8'd0);
        frame(8'h5A, 8'd1);
        idle_hold(10, 8'd1);

        // Reset during the second cycle of DATA bit 3.
        do_reset();
        tx_buf[0] = 32'h44434241;
        tail = 32'd1;
        tick();
        for (int unsigned c = 0; c < 17; c++) tick();
        chk("midframe_bit3", {31'd0, uart_tx}, 32'd0);
        chk("midframe_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("abort_tx", {31'd0, uart_tx}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_head", head_out, 32'd0);
        rst_n = 1'b1;
        tick();
        frame(8'h41, 8'd1);
        idle_hold(10, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
